pcm_tone_gear: RTL
==================

# pcm_tone_gear

Multi-channel, parametrised test-tone source for the PCM path. Each channel runs a phase accumulator and quarter-wave sine lookup at a programmable sample rate derived from `mclk`. A gain stage with click-free mute ramp scales the samples, and each frame is presented on a valid/ready handshake to the downstream PCM serialiser. It replaces fixed-rate, fixed-amplitude tone generation with runtime-selectable rate, per-channel frequency and level.

## Interface
- `NCH`, 2: number of output channels.
- `PHASE_W`, 32: phase accumulator / angle width.
- `DATA_W`, 32: signed sample width.
- `LUT_AW`, 8: quarter-wave LUT address bits (LUT holds 2^LUT_AW+1 entries).
- `LEVEL_W`, 16: unsigned gain, Q1.15 format.
- `DIV_W`, 12: sample-rate divider width.
- `RAMP_STEP`, 16'h0100: per-frame gain step toward target.
- `mclk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: 1 sets gain target = `level`; 0 sets target = 0.
- `div` in DIV_W: `mclk` cycles per sample. Effective value is max(`div`, NCH+4).
- `angle` in NCH*PHASE_W: per-channel phase increment per sample. Channel c occupies bits [c*PHASE_W +: PHASE_W].
- `level` in LEVEL_W: target gain. Values above 16'h8000 clamp to 16'h8000 (1.0).
- `out_valid` out 1: frame available.
- `out_ready` in 1: downstream accepts frame.
- `out_data` out NCH*DATA_W: frame, channel c at [c*DATA_W +: DATA_W].
- `overrun` out 1: one-cycle pulse when a frame is dropped.

## Operation
- Divider: `cnt` counts 0..eff_div-1 and wraps to 0. `tick` asserts when `cnt` == eff_div-1. A change to `div` takes effect at the next wrap.
- Frame FSM states:
  - IDLE: on `tick`, go to CALC with ch=0.
  - CALC: issue channel `ch` to the LUT, ch++. After ch=NCH-1, go to DRAIN.
  - DRAIN: wait 2 cycles for pipeline flush, then go to PRESENT.
  - PRESENT: `out_valid`=1. On `out_valid`&&`out_ready`, go to IDLE.
- Per channel in CALC:
  - Sample the current phase[c]; the pre-add value is used for the lookup.
  - Then phase[c] += angle[c], modulo 2^PHASE_W.
  - The top 2 bits form the quadrant q. The next LUT_AW bits form a.
  - LUT address = q odd ? 2^LUT_AW - a : a.
  - Result is negated for q >= 2.
  - LUT[k] = round((2^(DATA_W-1)-1)*sin(pi/2*k/2^LUT_AW)), so LUT[0]=0 and LUT[2^LUT_AW]=FS=2^(DATA_W-1)-1.
- Gain: sample = (sine * g) >>> 15, where the product is DATA_W+LEVEL_W wide signed and the result is truncated to DATA_W. With g ≤ 16'h8000 no overflow is possible.
- Ramp: g updates once per frame, at FSM entry to CALC.
  - g moves toward the target by RAMP_STEP.
  - If |target-g| ≤ RAMP_STEP, g = target.
  - All channels of one frame share the same g.
- Overrun: if `tick` fires while not in IDLE:
  - Phases still advance by angle (no frequency drift).
  - The pending frame and `out_data` stay unchanged.
  - The new frame is discarded.
  - `overrun` pulses for 1 cycle.
- `out_data` is stable while `out_valid`=1 and not accepted.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `overrun`=0.
  - `cnt`=0, all phases=0, g=0.
  - FSM in IDLE.
- Reset mid-frame aborts the frame; `out_valid` is 0 in the cycle after reset is sampled.
- The first `tick` occurs eff_div cycles after reset deasserts.
- Latency: `out_valid` rises NCH+3 cycles after the `tick` cycle. This breaks down as 1 cycle into CALC, NCH issue cycles, and the 2-cycle LUT + multiply pipeline.
- The LUT read is registered (1 cycle). The multiply result is registered (1 cycle).
- Minimum eff_div = NCH+4 guarantees IDLE is reached before the next `tick` when `out_ready` is held at 1.
- Simultaneous `tick` and acceptance in PRESENT: acceptance wins, the FSM goes to IDLE, and the `tick` counts as an overrun (frame dropped).

## Structure
- Package `pcm_tone_pkg`: FSM state enum (IDLE, CALC, DRAIN, PRESENT), `GAIN_ONE`=16'h8000, a quadrant decode function, and the LUT init function.
- Sub-module `pcm_sine_qlut`:
  - Ports: `mclk`, phase in, signed sample out.
  - Contains quadrant mirroring, the 2^LUT_AW+1 entry ROM, and negation, with 1-cycle registered latency.
- Top level contains the divider, the per-channel phase register array, the ramp, the FSM, the multiplier and the output register.

## Test plan
- Quarter-turn tone:
  - Stimulus: reset, NCH=2, div=16, angle0=2^30, angle1=2^31, level=16'h8000, enable=1, `out_ready`=1.
  - Response after ramp completes: ch0 samples 0, FS, 0, -FS (0x80000001) repeating; ch1 samples 0, 0 repeating.
- Ramp:
  - Stimulus: enable rises with level=16'h8000.
  - Response: g = 0x0100, 0x0200, …, 0x8000 over 128 frames. Drop enable: g returns to 0 over 128 frames and output is 0 thereafter.
- Backpressure:
  - Stimulus: `out_ready`=0 for 3 tick periods.
  - Response: first frame held stable, `overrun` pulses 3 times. Release ready: the first frame is accepted, and phase continuity is shown by the next frame matching sample index 4.
- Divider clamp:
  - Stimulus: div=0 with NCH=2.
  - Response: `tick` period is exactly 6 cycles, and `out_valid` occurs 5 cycles after each tick.
- Reset mid-frame:
  - Stimulus: assert reset during CALC.
  - Response: `out_valid`=0 next cycle, phases=0, g=0, and the next first frame ch0 = 0.
- Level clamp:
  - Stimulus: level=16'hFFFF.
  - Response: ch0 peak = FS exactly, with no wrap.

Source files
------------

// File: rtl/pcm_tone_pkg.sv
// Shared types and elaboration-time helpers for the PCM test-tone source:
// frame FSM states, unity gain, quadrant decode and the quarter-wave table values.
package pcm_tone_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DRAIN, PRESENT} frame_state_e;

  localparam logic [15:0] GAIN_ONE = 16'h8000;

  typedef struct packed {
    logic mirror;
    logic negate;
  } quad_t;

  function automatic quad_t quad_decode(input logic [1:0] q);
    return '{mirror: q[0], negate: q[1]};
  endfunction

  // Rounded full-scale sine of the k-th quarter-wave step, evaluated at elaboration.
  function automatic longint lut_entry(input int k, input int aw, input int dw);
    real fs;
    real x;
    fs = (2.0 ** (dw - 1)) - 1.0;
    x  = fs * $sin(3.14159265358979323846 / 2.0 * real'(k) / (2.0 ** aw));
    return longint'(x);
  endfunction

endpackage

// File: rtl/pcm_sine_qlut.sv
// Quarter-wave sine lookup: mirrors odd quadrants, negates the lower half-turn,
// one registered cycle from angle to signed sample.
module pcm_sine_qlut
  import pcm_tone_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LUT_AW = 8
) (
  input  logic                     mclk,
  input  logic [LUT_AW+1:0]        phase_i,
  output logic signed [DATA_W-1:0] sample_o
);

  localparam int NENT = (1 << LUT_AW) + 1;
  localparam logic [LUT_AW:0] QTR = (LUT_AW+1)'(1 << LUT_AW);

  logic [DATA_W-1:0] rom [NENT];

  for (genvar k = 0; k < NENT; k++) begin : g_rom
    localparam longint V = lut_entry(k, LUT_AW, DATA_W);
    assign rom[k] = DATA_W'(V);
  end

  quad_t                     qd;
  logic [LUT_AW-1:0]         a;
  logic [LUT_AW:0]           addr;
  logic signed [DATA_W-1:0]  mag;
  logic signed [DATA_W-1:0]  sample_q;

  assign qd   = quad_decode(phase_i[LUT_AW+1:LUT_AW]);
  assign a    = phase_i[LUT_AW-1:0];
  assign addr = qd.mirror ? (QTR - {1'b0, a}) : {1'b0, a};
  assign mag  = $signed(rom[addr]);

  always_ff @(posedge mclk) begin
    sample_q <= qd.negate ? -mag : mag;
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/pcm_tone_gear.sv
// Multi-channel test-tone source: rate divider, per-channel phase accumulators,
// click-free gain ramp and a valid/ready frame output with overrun detection.
//
// state   | meaning
// IDLE    | waiting for the next sample tick
// CALC    | issuing one channel per cycle to the sine lookup
// DRAIN   | two cycles for lookup and multiply to flush
// PRESENT | frame held on out_data with out_valid until accepted
module pcm_tone_gear
  import pcm_tone_pkg::*;
#(
  parameter int                 NCH       = 2,
  parameter int                 PHASE_W   = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 LUT_AW    = 8,
  parameter int                 LEVEL_W   = 16,
  parameter int                 DIV_W     = 12,
  parameter logic [LEVEL_W-1:0] RAMP_STEP = 16'h0100
) (
  input  logic                     mclk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         div,
  input  logic [NCH*PHASE_W-1:0]   angle,
  input  logic [LEVEL_W-1:0]       level,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NCH*DATA_W-1:0]    out_data,
  output logic                     overrun
);

  localparam int                 CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int                 PROD_W  = DATA_W + LEVEL_W + 1;
  localparam logic [DIV_W-1:0]   DIV_MIN = DIV_W'(NCH + 4);
  localparam logic [LEVEL_W-1:0] G_ONE   = LEVEL_W'(GAIN_ONE);

  logic [DIV_W-1:0]          cnt_q, eff_q, div_clamped;
  logic                      tick, issue, drop;
  logic [PHASE_W-1:0]        phase_q [NCH];
  logic [LUT_AW+1:0]         lut_idx;
  logic signed [DATA_W-1:0]  sine;
  frame_state_e              state_q;
  logic [CH_W-1:0]           ch_q, lut_ch_q, mul_ch_q;
  logic                      drain_q, lut_v_q, mul_v_q;
  logic                      out_valid_q, overrun_q;
  logic [LEVEL_W-1:0]        g_q, g_d, target;
  logic signed [PROD_W-1:0]  prod_d, prod_q;
  logic [NCH*DATA_W-1:0]     out_data_q;

  // The divider period is latched at each wrap so a new div never truncates a period.
  assign div_clamped = (div < DIV_MIN) ? DIV_MIN : div;
  assign tick        = (cnt_q == eff_q - DIV_W'(1));

  always_ff @(posedge mclk) begin
    if (reset) begin
      cnt_q <= '0;
      eff_q <= div_clamped;
    end else if (tick) begin
      cnt_q <= '0;
      eff_q <= div_clamped;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

  assign issue = (state_q == CALC);
  assign drop  = tick && (state_q != IDLE);

  // Dropped ticks still advance every phase so the tone frequency never drifts.
  always_ff @(posedge mclk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        phase_q[c] <= '0;
      end else if (drop || (issue && ch_q == CH_W'(c))) begin
        phase_q[c] <= phase_q[c] + angle[c*PHASE_W +: PHASE_W];
      end
    end
  end

  assign lut_idx = phase_q[ch_q][PHASE_W-1 -: LUT_AW+2];

  pcm_sine_qlut #(
    .DATA_W (DATA_W),
    .LUT_AW (LUT_AW)
  ) u_qlut (
    .mclk     (mclk),
    .phase_i  (lut_idx),
    .sample_o (sine)
  );

  assign target = !enable ? '0 : ((level > G_ONE) ? G_ONE : level);

  always_comb begin
    g_d = g_q;
    if (target > g_q) begin
      g_d = (target - g_q <= RAMP_STEP) ? target : g_q + RAMP_STEP;
    end else if (target < g_q) begin
      g_d = (g_q - target <= RAMP_STEP) ? target : g_q - RAMP_STEP;
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      drain_q     <= 1'b0;
      g_q         <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= drop;
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= CALC;
            ch_q    <= '0;
            g_q     <= g_d;
          end
        end
        CALC: begin
          if (ch_q == CH_W'(NCH - 1)) begin
            state_q <= DRAIN;
            drain_q <= 1'b0;
          end else begin
            ch_q <= ch_q + CH_W'(1);
          end
        end
        DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q     <= PRESENT;
            out_valid_q <= 1'b1;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prod_d = PROD_W'(sine) * PROD_W'($signed({1'b0, g_q}));

  always_ff @(posedge mclk) begin
    if (reset) begin
      lut_v_q    <= 1'b0;
      lut_ch_q   <= '0;
      mul_v_q    <= 1'b0;
      mul_ch_q   <= '0;
      prod_q     <= '0;
      out_data_q <= '0;
    end else begin
      lut_v_q  <= issue;
      lut_ch_q <= ch_q;
      mul_v_q  <= lut_v_q;
      mul_ch_q <= lut_ch_q;
      prod_q   <= prod_d;
      if (mul_v_q) begin
        out_data_q[int'(mul_ch_q)*DATA_W +: DATA_W] <= DATA_W'(prod_q >>> (LEVEL_W - 1));
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;

endmodule
